// File: rtl/grid_entity_mover.sv
// Rate-limited grid entity mover: scans the level grid row-major, steps each enemy into an
// adjacent free cell, then runs a second pass that turns move markers back into enemies.
module grid_entity_mover #(
    parameter int unsigned GRID_W      = 40,
    parameter int unsigned GRID_H      = 30,
    parameter int unsigned XW          = 6,
    parameter int unsigned YW          = 5,
    parameter int unsigned CELL_W      = 3,
    parameter int unsigned ENEMY_CODE  = 4,
    parameter int unsigned AIR_CODE    = 0,
    parameter int unsigned MARK_CODE   = 5,
    parameter int unsigned MOVE_PERIOD = 200000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic [XW-1:0]        player_x,
    input  logic [YW-1:0]        player_y,
    output logic                 done,
    output logic                 busy,
    output logic [XW-1:0]        grid_x,
    output logic [YW-1:0]        grid_y,
    input  logic [CELL_W-1:0]    grid_out,
    output logic                 grid_write,
    output logic [CELL_W-1:0]    grid_in,
    output logic [XW+YW-1:0]     moved_count
);

    localparam int unsigned CW = $clog2(MOVE_PERIOD + 1);
    localparam int unsigned MW = XW + YW;
    localparam int unsigned DW = ((XW > YW) ? XW : YW) + 1;
    localparam logic [XW-1:0]     X_LAST = XW'(GRID_W - 1);
    localparam logic [YW-1:0]     Y_LAST = YW'(GRID_H - 1);
    localparam logic [CELL_W-1:0] ENEMY  = CELL_W'(ENEMY_CODE);
    localparam logic [CELL_W-1:0] AIR    = CELL_W'(AIR_CODE);
    localparam logic [CELL_W-1:0] MARK   = CELL_W'(MARK_CODE);

    typedef enum logic [4:0] {
        S_IDLE, S_GATE, S_SRD, S_SWT, S_SCHK, S_DRD, S_DWT, S_DCHK, S_WDST,
        S_WSRC, S_NEXT, S_FRD, S_FWT, S_FCHK, S_FWR, S_FNXT, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   addr_x_q, addr_x_d, pos_x_q, pos_x_d;
    logic [YW-1:0]   addr_y_q, addr_y_d, pos_y_q, pos_y_d;
    logic [CW-1:0]   period_q, period_d;
    logic [MW-1:0]   moved_q, moved_d;
    logic [15:0]     lfsr_q, lfsr_d;

    logic [DW-1:0]   dx, dy, adx, ady;
    logic [1:0]      dir;
    logic            want_move, dest_ok, last_cell;
    logic [XW-1:0]   dest_x, step_x;
    logic [YW-1:0]   dest_y, step_y;

    // Direction choice: random from the LFSR, or chase along the axis of larger distance.
    always_comb begin
        dx        = DW'(player_x) - DW'(pos_x_q);
        dy        = DW'(player_y) - DW'(pos_y_q);
        adx       = dx[DW-1] ? -dx : dx;
        ady       = dy[DW-1] ? -dy : dy;
        dir       = lfsr_q[1:0];
        want_move = 1'b1;
        if (mode) begin
            if (dx == '0 && dy == '0) begin
                want_move = 1'b0;
            end else if (adx >= ady) begin
                dir = dx[DW-1] ? 2'd3 : 2'd1;
            end else begin
                dir = dy[DW-1] ? 2'd0 : 2'd2;
            end
        end
        dest_x  = pos_x_q;
        dest_y  = pos_y_q;
        dest_ok = 1'b0;
        case (dir)
            2'd0: begin dest_ok = (pos_y_q != '0);     dest_y = pos_y_q - YW'(1); end
            2'd1: begin dest_ok = (pos_x_q != X_LAST); dest_x = pos_x_q + XW'(1); end
            2'd2: begin dest_ok = (pos_y_q != Y_LAST); dest_y = pos_y_q + YW'(1); end
            default: begin dest_ok = (pos_x_q != '0);  dest_x = pos_x_q - XW'(1); end
        endcase
        dest_ok   = dest_ok && want_move;
        last_cell = (pos_x_q == X_LAST) && (pos_y_q == Y_LAST);
        step_x    = (pos_x_q == X_LAST) ? '0 : pos_x_q + XW'(1);
        step_y    = (pos_x_q == X_LAST) ? pos_y_q + YW'(1) : pos_y_q;
    end

    always_comb begin
        state_d    = state_q;
        addr_x_d   = addr_x_q;
        addr_y_d   = addr_y_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        moved_d    = moved_q;
        period_d   = (period_q != '0) ? period_q - CW'(1) : period_q;
        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        grid_write = 1'b0;
        grid_in    = AIR;
        done       = 1'b0;
        busy       = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: if (start) state_d = S_GATE;
            S_GATE: begin
                if (period_q != '0) begin
                    state_d = S_DONE;
                end else begin
                    period_d = CW'(MOVE_PERIOD - 1);
                    moved_d  = '0;
                    addr_x_d = '0;
                    addr_y_d = '0;
                    pos_x_d  = '0;
                    pos_y_d  = '0;
                    state_d  = S_SRD;
                end
            end
            S_SRD:  state_d = S_SWT;
            S_SWT:  state_d = S_SCHK;
            S_SCHK: begin
                if (grid_out == ENEMY && dest_ok) begin
                    addr_x_d = dest_x;
                    addr_y_d = dest_y;
                    state_d  = S_DRD;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_DRD:  state_d = S_DWT;
            S_DWT:  state_d = S_DCHK;
            S_DCHK: state_d = (grid_out == AIR) ? S_WDST : S_NEXT;
            S_WDST: begin
                grid_write = 1'b1;
                grid_in    = MARK;
                addr_x_d   = pos_x_q;
                addr_y_d   = pos_y_q;
                state_d    = S_WSRC;
            end
            S_WSRC: begin
                grid_write = 1'b1;
                grid_in    = AIR;
                moved_d    = moved_q + MW'(1);
                state_d    = S_NEXT;
            end
            S_NEXT: begin
                if (last_cell) begin
                    pos_x_d = '0;
                    pos_y_d = '0;
                    state_d = S_FRD;
                end else begin
                    pos_x_d = step_x;
                    pos_y_d = step_y;
                    state_d = S_SRD;
                end
                addr_x_d = last_cell ? '0 : step_x;
                addr_y_d = last_cell ? '0 : step_y;
            end
            S_FRD:  state_d = S_FWT;
            S_FWT:  state_d = S_FCHK;
            S_FCHK: state_d = (grid_out == MARK) ? S_FWR : S_FNXT;
            S_FWR: begin
                grid_write = 1'b1;
                grid_in    = ENEMY;
                state_d    = S_FNXT;
            end
            S_FNXT: begin
                if (last_cell) begin
                    state_d = S_DONE;
                end else begin
                    pos_x_d  = step_x;
                    pos_y_d  = step_y;
                    addr_x_d = step_x;
                    addr_y_d = step_y;
                    state_d  = S_FRD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_x_q <= '0;
            addr_y_q <= '0;
            pos_x_q  <= '0;
            pos_y_q  <= '0;
            period_q <= '0;
            moved_q  <= '0;
            lfsr_q   <= LFSR_SEED;
        end else begin
            state_q  <= state_d;
            addr_x_q <= addr_x_d;
            addr_y_q <= addr_y_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            period_q <= period_d;
            moved_q  <= moved_d;
            lfsr_q   <= lfsr_d;
        end
    end

    assign grid_x      = addr_x_q;
    assign grid_y      = addr_y_q;
    assign moved_count = moved_q;

endmodule

// File: tb/tb_grid_entity_mover.sv
// Directed bench for grid_entity_mover: a behavioural 1-cycle-latency grid RAM plus
// hand-computed expectations for empty, chase, edge, blocked, gated and reset-abort scans.
module tb_grid_entity_mover;

    localparam int GW = 40;
    localparam int GH = 30;

    logic        clock = 1'b0;
    logic        reset, start, mode;
    logic [5:0]  player_x;
    logic [4:0]  player_y;
    logic        done, busy, grid_write;
    logic [5:0]  grid_x;
    logic [4:0]  grid_y;
    logic [2:0]  grid_out, grid_in;
    logic [10:0] moved_count;

    logic        tb_clr, tb_we;
    logic [5:0]  tb_wx;
    logic [4:0]  tb_wy;
    logic [2:0]  tb_wv;
    logic [2:0]  mem [GW][GH];
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          n_total = 0;
    int          n_pass = 0;

    grid_entity_mover #(.GRID_W(GW), .GRID_H(GH)) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .player_x(player_x), .player_y(player_y), .done(done), .busy(busy),
        .grid_x(grid_x), .grid_y(grid_y), .grid_out(grid_out),
        .grid_write(grid_write), .grid_in(grid_in), .moved_count(moved_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (tb_clr) begin
            for (int i = 0; i < GW; i++)
                for (int j = 0; j < GH; j++)
                    mem[i][j] <= 3'd0;
        end else if (tb_we) begin
            mem[tb_wx][tb_wy] <= tb_wv;
        end else if (grid_write) begin
            mem[grid_x][grid_y] <= grid_in;
        end
        grid_out <= mem[grid_x][grid_y];
        if (grid_write) wr_cnt <= wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic poke(input int x, input int y, input int v);
        tb_wx = 6'(x); tb_wy = 5'(y); tb_wv = 3'(v); tb_we = 1'b1;
        tick();
        tb_we = 1'b0;
    endtask

    task automatic clear_grid();
        tb_clr = 1'b1;
        tick();
        tb_clr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    // Returns at the negedge of the DONE cycle (or after the budget runs out).
    task automatic run_scan();
        int n;
        n = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!done && n < 20000) begin
            tick();
            n++;
        end
        if (!done) check("scan_timeout", 0, 1);
    endtask

    initial begin
        int w0, d0;
        reset = 1'b1; start = 1'b0; mode = 1'b0; player_x = '0; player_y = '0;
        tb_clr = 1'b0; tb_we = 1'b0; tb_wx = '0; tb_wy = '0; tb_wv = '0;
        clear_grid();
        tick();
        reset = 1'b0;
        tick();
        check("rst_write", int'(grid_write), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_x", int'(grid_x), 0);
        check("rst_y", int'(grid_y), 0);
        check("rst_in", int'(grid_in), 0);
        check("rst_moved", int'(moved_count), 0);

        // Empty grid
        w0 = wr_cnt; d0 = done_cnt;
        run_scan();
        repeat (3) tick();
        check("empty_writes", wr_cnt - w0, 0);
        check("empty_dones", done_cnt - d0, 1);
        check("empty_moved", int'(moved_count), 0);

        // Chase right by one, then DONE-cycle start ignored, then gated start
        do_reset(); clear_grid();
        poke(5, 5, 4);
        mode = 1'b1; player_x = 6'd10; player_y = 5'd5;
        w0 = wr_cnt;
        run_scan();
        check("chase_writes", wr_cnt - w0, 3);
        check("chase_dst", int'(mem[6][5]), 4);
        check("chase_src", int'(mem[5][5]), 0);
        check("chase_moved", int'(moved_count), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("donecyc_busy0", int'(busy), 0);
        tick();
        check("donecyc_busy1", int'(busy), 0);
        check("donecyc_done", int'(done), 0);
        w0 = wr_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("gate_busy", int'(busy), 1);
        check("gate_done_early", int'(done), 0);
        tick();
        check("gate_done", int'(done), 1);
        tick();
        check("gate_writes", wr_cnt - w0, 0);
        check("gate_moved_held", int'(moved_count), 1);
        check("gate_busy_after", int'(busy), 0);

        // Edge, wall-blocked, no-double-move and vertical chase in one scan
        do_reset(); clear_grid();
        poke(39, 3, 4); poke(10, 3, 4); poke(11, 3, 1); poke(20, 3, 4); poke(39, 28, 4);
        mode = 1'b1; player_x = 6'd63; player_y = 5'd3;
        w0 = wr_cnt;
        run_scan();
        check("mix_writes", wr_cnt - w0, 6);
        check("mix_moved", int'(moved_count), 2);
        check("mix_edge", int'(mem[39][3]), 4);
        check("mix_blocked", int'(mem[10][3]), 4);
        check("mix_wall", int'(mem[11][3]), 1);
        check("mix_src", int'(mem[20][3]), 0);
        check("mix_dst", int'(mem[21][3]), 4);
        check("mix_no_double", int'(mem[22][3]), 0);
        check("mix_up_dst", int'(mem[39][27]), 4);
        check("mix_up_src", int'(mem[39][28]), 0);

        // Random mode at left edge, every neighbour walled
        do_reset(); clear_grid();
        poke(0, 7, 4); poke(0, 6, 1); poke(1, 7, 1); poke(0, 8, 1);
        mode = 1'b0;
        w0 = wr_cnt;
        run_scan();
        check("rand_writes", wr_cnt - w0, 0);
        check("rand_moved", int'(moved_count), 0);
        check("rand_cell", int'(mem[0][7]), 4);

        // Reset in the middle of a scan
        do_reset(); clear_grid();
        poke(30, 25, 4);
        mode = 1'b1; player_x = 6'd39; player_y = 5'd25;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2000) tick();
        check("abort_busy_before", int'(busy), 1);
        w0 = wr_cnt;
        reset = 1'b1;
        tick();
        check("abort_write", int'(grid_write), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_x", int'(grid_x), 0);
        reset = 1'b0;
        repeat (200) tick();
        check("abort_writes", wr_cnt - w0, 0);
        check("abort_cell", int'(mem[30][25]), 4);
        check("abort_busy_after", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
